// File: rtl/shr_arbiter.sv
// shr_arbiter: round-robin arbiter sharing one right-shift unit among NREQ requesters.
// The result sits in a single-entry output register with valid/ready handshake.
//
// Optional feature macro: SHR_ARBITER_ARITH_EN
//   defined   -> req_arith_i[winner]=1 selects a sign-filling arithmetic shift
//   undefined -> req_arith_i is ignored, every shift is logical
//
// Ports:
//   clk_i         rising-edge clock
//   rst_ni        asynchronous active-low reset
//   req_valid_i   per-requester request valid            [NREQ]
//   req_ready_o   per-requester accept, one-hot or zero  [NREQ]
//   req_a_i       packed operands, i at [i*DATAWIDTH +: DATAWIDTH]
//   req_sh_amt_i  packed shift amounts, same packing
//   req_arith_i   per-requester arithmetic-shift select  [NREQ]
//   rsp_valid_o   result valid
//   rsp_ready_i   consumer accepts result
//   rsp_data_o    shift result                           [DATAWIDTH]
//   rsp_id_o      index of requester that produced rsp_data_o [IDW]
module shr_arbiter #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned NREQ      = 4,
  parameter int unsigned IDW       = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NREQ-1:0]           req_valid_i,
  output logic [NREQ-1:0]           req_ready_o,
  input  logic [NREQ*DATAWIDTH-1:0] req_a_i,
  input  logic [NREQ*DATAWIDTH-1:0] req_sh_amt_i,
  input  logic [NREQ-1:0]           req_arith_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [DATAWIDTH-1:0]      rsp_data_o,
  output logic [IDW-1:0]            rsp_id_o
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e               state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [DATAWIDTH-1:0] data_q, data_d;
  logic [IDW-1:0]       id_q, id_d;

  logic                 found;
  logic [IDW-1:0]       winner;
  logic [IDW-1:0]       cand;
  logic                 can_take;
  logic                 accept;
  logic [DATAWIDTH-1:0] sel_a;
  logic [DATAWIDTH-1:0] sel_sh;
  logic                 do_arith;
  logic [DATAWIDTH-1:0] shifted;

  assign rsp_valid_o = (state_q == StFull);
  assign rsp_data_o  = data_q;
  assign rsp_id_o    = id_q;

  // Scan from rr_ptr_q upward, wrapping at NREQ; first valid requester wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(rr_ptr_q) + k) % NREQ);
      if (!found && req_valid_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign can_take = !rsp_valid_o || rsp_ready_i;
  // Gate with rst_ni so nothing is granted (or accepted) while reset is held.
  assign accept   = found && can_take && rst_ni;

  always_comb begin
    req_ready_o = '0;
    if (accept) begin
      req_ready_o[winner] = 1'b1;
    end
  end

  assign sel_a  = req_a_i[32'(winner)*DATAWIDTH +: DATAWIDTH];
  assign sel_sh = req_sh_amt_i[32'(winner)*DATAWIDTH +: DATAWIDTH];

`ifdef SHR_ARBITER_ARITH_EN
  assign do_arith = req_arith_i[winner];
`else
  logic unused_arith;
  assign unused_arith = ^req_arith_i;
  assign do_arith     = 1'b0;
`endif

  // Full-width compare of the shift amount: anything >= DATAWIDTH saturates to the fill value.
  always_comb begin
    shifted = sel_a >> sel_sh;
    if (32'(sel_sh) >= DATAWIDTH) begin
      shifted = do_arith ? {DATAWIDTH{sel_a[DATAWIDTH-1]}} : '0;
    end else if (do_arith) begin
      shifted = DATAWIDTH'($signed(sel_a) >>> sel_sh);
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    id_d     = id_q;
    unique case (state_q)
      StEmpty: if (accept) state_d = StFull;
      StFull:  if (!accept && rsp_ready_i) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
    if (accept) begin
      data_d   = shifted;
      id_d     = winner;
      rr_ptr_d = IDW'((32'(winner) + 1) % NREQ);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StEmpty;
      rr_ptr_q <= '0;
      data_q   <= '0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      id_q     <= id_d;
    end
  end

endmodule
